// File: rtl/code_defs_pkg.sv
// rtl/code_defs_pkg.sv - shared link-state enum, sync header codes and header check
package code_defs_pkg;

  typedef enum logic [1:0] {
    RESET_XVER = 2'd0,
    WAIT_XVER  = 2'd1,
    WAIT_LOCK  = 2'd2,
    LINK_UP    = 2'd3
  } link_state_t;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Only 01 and 10 are legal 66b sync headers; 00 and 11 are errors.
  function automatic logic header_invalid(input logic [1:0] header);
    return (header != SYNC_DATA) && (header != SYNC_CTRL);
  endfunction

endpackage

// File: rtl/ber_monitor.sv
// rtl/ber_monitor.sv - windowed invalid-sync-header counter producing hi_ber
module ber_monitor
  import code_defs_pkg::*;
#(
  parameter int BER_WINDOW = 19531,
  parameter int BER_THRESH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       block_lock,
  input  logic [1:0] header,
  input  logic       header_valid,
  output logic       hi_ber
);

  localparam int BW = $clog2(BER_WINDOW) + 1;
  localparam int EW = $clog2(BER_THRESH) + 1;
  localparam logic [BW-1:0] BLK_LAST = BW'(BER_WINDOW - 1);
  localparam logic [EW-1:0] ERR_MAX  = EW'(BER_THRESH);

  logic [BW-1:0] blk_cnt;
  logic [EW-1:0] err_cnt;
  logic [EW-1:0] err_next;
  logic          bad_block;
  logic          wrap;

  // Error count including the current block, held at the threshold once reached.
  always_comb begin
    bad_block = header_valid && header_invalid(header);
    err_next  = err_cnt;
    if (bad_block && (err_cnt != ERR_MAX)) begin
      err_next = err_cnt + 1'b1;
    end
    wrap = (blk_cnt == BLK_LAST);
  end

  // Window bookkeeping; everything is held clear while block lock is absent.
  always_ff @(posedge clk) begin
    if (reset || !block_lock) begin
      blk_cnt <= '0;
      err_cnt <= '0;
      hi_ber  <= 1'b0;
    end else if (header_valid) begin
      if (wrap) begin
        // Window verdict: this is the only place hi_ber can clear.
        blk_cnt <= '0;
        err_cnt <= '0;
        hi_ber  <= (err_next >= ERR_MAX);
      end else begin
        blk_cnt <= blk_cnt + 1'b1;
        err_cnt <= err_next;
        if (err_next >= ERR_MAX) begin
          hi_ber <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pcs_link_ctrl.sv
// rtl/pcs_link_ctrl.sv - RX link bring-up FSM, lock timeout retry, BER supervision; stats under PCS_LINK_STATS_EN
module pcs_link_ctrl
  import code_defs_pkg::*;
#(
  parameter int RESET_CYCLES = 64,
  parameter int LOCK_TIMEOUT = 500000,
  parameter int BER_WINDOW   = 19531,
  parameter int BER_THRESH   = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_xver_rx_done,
  input  logic        i_block_lock,
  input  logic [1:0]  i_header,
  input  logic        i_header_valid,
  output logic        o_xver_rx_reset,
  output logic        o_pcs_rx_reset,
  output logic        o_link_up,
  output logic        o_hi_ber,
  output logic [7:0]  o_retry_count,
  output logic [15:0] o_lock_loss_count,
  output logic [15:0] o_err_block_count
);

  localparam int RW = $clog2(RESET_CYCLES) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);

  link_state_t   state;
  link_state_t   next_state;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] lock_timer;
  logic          retry_inc;
  logic          hi_ber;

  ber_monitor #(
    .BER_WINDOW (BER_WINDOW),
    .BER_THRESH (BER_THRESH)
  ) u_ber_monitor (
    .clk          (i_clk),
    .reset        (i_reset),
    .block_lock   (i_block_lock),
    .header       (i_header),
    .header_valid (i_header_valid),
    .hi_ber       (hi_ber)
  );

  assign o_hi_ber = hi_ber;

  // Next-state decode; transceiver loss outranks lock loss, which outranks hi_ber.
  always_comb begin
    next_state = state;
    retry_inc  = 1'b0;
    case (state)
      RESET_XVER: begin
        if (rst_cnt == RST_LAST) next_state = WAIT_XVER;
      end
      WAIT_XVER: begin
        if (i_xver_rx_done) next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (!i_xver_rx_done) begin
          next_state = RESET_XVER;
        end else if (i_block_lock && !hi_ber) begin
          next_state = LINK_UP;
        end else if (lock_timer == TMO_LAST) begin
          next_state = RESET_XVER;
          retry_inc  = 1'b1;
        end
      end
      LINK_UP: begin
        if (!i_xver_rx_done) begin
          next_state = RESET_XVER;
        end else if (!i_block_lock || hi_ber) begin
          next_state = WAIT_LOCK;
        end
      end
      default: next_state = RESET_XVER;
    endcase
  end

  // State register and per-state timers; timers restart on every state entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= RESET_XVER;
      rst_cnt    <= '0;
      lock_timer <= '0;
    end else begin
      state      <= next_state;
      rst_cnt    <= (state == RESET_XVER && next_state == RESET_XVER) ? rst_cnt + 1'b1 : '0;
      lock_timer <= (state == WAIT_LOCK && next_state == WAIT_LOCK) ? lock_timer + 1'b1 : '0;
    end
  end

  // Outputs registered from the next state so they change on the transition edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_xver_rx_reset <= 1'b1;
      o_pcs_rx_reset  <= 1'b1;
      o_link_up       <= 1'b0;
      o_retry_count   <= 8'd0;
    end else begin
      o_xver_rx_reset <= (next_state == RESET_XVER);
      o_pcs_rx_reset  <= (next_state == RESET_XVER) || (next_state == WAIT_XVER);
      o_link_up       <= (next_state == LINK_UP);
      if (retry_inc && (o_retry_count != 8'hFF)) begin
        o_retry_count <= o_retry_count + 8'd1;
      end
    end
  end

`ifdef PCS_LINK_STATS_EN
  logic stat_bad;
  assign stat_bad = i_header_valid && i_block_lock && header_invalid(i_header);

  // Saturating link statistics, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_lock_loss_count <= 16'd0;
      o_err_block_count <= 16'd0;
    end else begin
      if ((state == LINK_UP) && (next_state != LINK_UP) && (o_lock_loss_count != 16'hFFFF)) begin
        o_lock_loss_count <= o_lock_loss_count + 16'd1;
      end
      if (stat_bad && (o_err_block_count != 16'hFFFF)) begin
        o_err_block_count <= o_err_block_count + 16'd1;
      end
    end
  end
`else
  assign o_lock_loss_count = 16'd0;
  assign o_err_block_count = 16'd0;
`endif

endmodule

// File: tb/tb_pcs_link_ctrl.sv
// tb/tb_pcs_link_ctrl.sv - scoreboard bench for pcs_link_ctrl (bring-up, BER, timeout, priority, stats)
module tb_pcs_link_ctrl;

  logic        clk;
  logic        reset;
  logic        xver_done;
  logic        lock;
  logic [1:0]  header;
  logic        hv;
  logic        xver_rx_reset;
  logic        pcs_rx_reset;
  logic        link_up;
  logic        hi_ber;
  logic [7:0]  retry_count;
  logic [15:0] lock_loss_count;
  logic [15:0] err_block_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_ll       = 0;
  int exp_eb       = 0;

  string        q_name[$];
  logic [43:0]  q_exp[$];

  pcs_link_ctrl #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (100),
    .BER_WINDOW   (64),
    .BER_THRESH   (16)
  ) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_xver_rx_done    (xver_done),
    .i_block_lock      (lock),
    .i_header          (header),
    .i_header_valid    (hv),
    .o_xver_rx_reset   (xver_rx_reset),
    .o_pcs_rx_reset    (pcs_rx_reset),
    .o_link_up         (link_up),
    .o_hi_ber          (hi_ber),
    .o_retry_count     (retry_count),
    .o_lock_loss_count (lock_loss_count),
    .o_err_block_count (err_block_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Queue the outputs expected after the edge that has just passed.
  task automatic expect_out(input string name, input logic xr, input logic pr,
                            input logic up, input logic hb, input int retry);
    logic [15:0] ll;
    logic [15:0] eb;
`ifdef PCS_LINK_STATS_EN
    ll = 16'(exp_ll);
    eb = 16'(exp_eb);
`else
    ll = 16'd0;
    eb = 16'd0;
`endif
    q_name.push_back(name);
    q_exp.push_back({xr, pr, up, hb, 8'(retry), ll, eb});
  endtask

  // Immediate comparison of the outputs right after an edge.
  task automatic check_now(input string name, input logic xr, input logic pr,
                           input logic up, input logic hb, input int retry);
    logic [15:0] ll;
    logic [15:0] eb;
    logic [43:0] e;
    logic [43:0] a;
`ifdef PCS_LINK_STATS_EN
    ll = 16'(exp_ll);
    eb = 16'(exp_eb);
`else
    ll = 16'd0;
    eb = 16'd0;
`endif
    e = {xr, pr, up, hb, 8'(retry), ll, eb};
    a = {xver_rx_reset, pcs_rx_reset, link_up, hi_ber, retry_count,
         lock_loss_count, err_block_count};
    tests_run++;
    if (a !== e) begin
      tests_failed++;
      $display("FAIL %s (direct): got xr=%0b pr=%0b up=%0b hb=%0b retry=%0d ll=%0d eb=%0d, expected xr=%0b pr=%0b up=%0b hb=%0b retry=%0d ll=%0d eb=%0d",
               name, a[43], a[42], a[41], a[40], a[39:32], a[31:16], a[15:0],
               e[43], e[42], e[41], e[40], e[39:32], e[31:16], e[15:0]);
    end
  endtask

  function automatic logic [1:0] hdr_for(input int b);
    if (b >= 10 && b <= 24) return (b % 2 == 1) ? 2'b00 : 2'b11;
    if (b >= 112 && b <= 127) return 2'b11;
    return (b % 3 == 0) ? 2'b10 : 2'b01;
  endfunction

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  always @(negedge clk) begin
    while (q_exp.size() > 0) begin
      logic [43:0] e;
      logic [43:0] a;
      string       n;
      e = q_exp.pop_front();
      n = q_name.pop_front();
      a = {xver_rx_reset, pcs_rx_reset, link_up, hi_ber, retry_count,
           lock_loss_count, err_block_count};
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL %s: got xr=%0b pr=%0b up=%0b hb=%0b retry=%0d ll=%0d eb=%0d, expected xr=%0b pr=%0b up=%0b hb=%0b retry=%0d ll=%0d eb=%0d",
                 n, a[43], a[42], a[41], a[40], a[39:32], a[31:16], a[15:0],
                 e[43], e[42], e[41], e[40], e[39:32], e[31:16], e[15:0]);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    xver_done = 1'b0;
    lock      = 1'b0;
    header    = 2'b01;
    hv        = 1'b0;

    tick;
    expect_out("reset_hold", 1, 1, 0, 0, 0);
    check_now("reset_state", 1, 1, 0, 0, 0);
    tick;
    expect_out("reset_hold2", 1, 1, 0, 0, 0);

    // Normal bring-up: xr high for cycles 0-3, WAIT_XVER one cycle, lock at cycle 20.
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick;
      expect_out($sformatf("bringup_k%0d", k), k <= 3, k <= 4, k >= 20, 0, 0);
      if (k == 1) xver_done = 1'b1;
      if (k == 19) lock = 1'b1;
    end

    // BER: window 0 has 15 mixed errors, window 1 ends with 16 errors, window 2 clean.
    for (int b = 0; b < 200; b++) begin
      header = hdr_for(b);
      hv     = 1'b1;
      tick;
      if (header == 2'b00 || header == 2'b11) exp_eb++;
      if (b == 128) exp_ll++;
      expect_out($sformatf("ber_b%0d", b), 0, 0, !(b >= 128 && b <= 191),
                 (b >= 127 && b <= 190), 0);
    end

    // Transceiver and lock lost together: reset path, no retry.
    hv        = 1'b0;
    header    = 2'b01;
    xver_done = 1'b0;
    lock      = 1'b0;
    tick;
    exp_ll++;
    expect_out("prio_drop", 1, 1, 0, 0, 0);
    xver_done = 1'b1;

    // Lock never arrives: 105-cycle retry period, retry count saturates at 255.
    for (int c = 1; c <= 31510; c++) begin
      tick;
      expect_out("timeout", (c % 105) < 4, (c % 105) < 5, 0, 0,
                 (c / 105 > 255) ? 255 : c / 105);
    end
    check_now("timeout_expired", 0, 0, 0, 0, 255);

    // Reset in the middle of WAIT_LOCK.
    reset = 1'b1;
    tick;
    exp_ll = 0;
    exp_eb = 0;
    expect_out("reset_abort", 1, 1, 0, 0, 0);
    check_now("reset_abort_direct", 1, 1, 0, 0, 0);
    lock  = 1'b1;
    reset = 1'b0;
    for (int g = 1; g <= 6; g++) begin
      tick;
      expect_out($sformatf("rebringup_g%0d", g), g <= 3, g <= 4, g >= 6, 0, 0);
    end

    // Three lock drops and five invalid headers for the statistics.
    for (int i = 0; i < 3; i++) begin
      lock = 1'b0;
      tick;
      exp_ll++;
      expect_out("stats_drop", 0, 0, 0, 0, 0);
      lock = 1'b1;
      tick;
      expect_out("stats_relock", 0, 0, 1, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      hv     = 1'b1;
      header = (i % 2 == 1) ? 2'b00 : 2'b11;
      tick;
      exp_eb++;
      expect_out("stats_err", 0, 0, 1, 0, 0);
    end
    hv     = 1'b0;
    header = 2'b01;
    tick;
    expect_out("stats_final", 0, 0, 1, 0, 0);

    tick;
    tick;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
